// File: rtl/cc_cmp_arbiter_pkg.sv
// cc_cmp_arbiter_pkg: FSM state encoding and channel-index width helper
// shared by the compare arbiter and its bench.
package cc_cmp_arbiter_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, COMPARE = 2'd2, DONE = 2'd3} state_e;
   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/cc_cmp_arbiter_core.sv
// cc_cmp_core: unsigned comparator, lt_n_o is low only when a_i < b_i.
module cc_cmp_core #(
   parameter int W = 8
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   output logic         lt_n_o
);
   assign lt_n_o = !(a_i < b_i);
endmodule

// File: rtl/cc_cmp_arbiter.sv
// cc_cmp_arbiter: round-robin arbiter serving one shared unsigned comparator.
// Define CC_CMP_ARBITER_RESULTS_EN to add the per-channel result register output.
module cc_cmp_arbiter
   import cc_cmp_arbiter_pkg::*;
#(
   parameter int NUMBER_DATAWIDTH = 8,
   parameter int NUMBER_CHANNELS  = 4
) (
   input  logic                                         CC_CMP_ARBITER_CLOCK_50,
   input  logic                                         CC_CMP_ARBITER_RESET_InLow,
   input  logic [NUMBER_CHANNELS-1:0]                   CC_CMP_ARBITER_req_InBUS,
   input  logic [NUMBER_CHANNELS*NUMBER_DATAWIDTH-1:0]  CC_CMP_ARBITER_dataA_InBUS,
   input  logic [NUMBER_CHANNELS*NUMBER_DATAWIDTH-1:0]  CC_CMP_ARBITER_dataB_InBUS,
   output logic [NUMBER_CHANNELS-1:0]                   CC_CMP_ARBITER_grant_OutBUS,
   output logic                                         CC_CMP_ARBITER_valid_Out,
   output logic [idx_w(NUMBER_CHANNELS)-1:0]            CC_CMP_ARBITER_channel_OutBUS,
   output logic                                         CC_CMP_ARBITER_lessthan_OutLow,
`ifdef CC_CMP_ARBITER_RESULTS_EN
   output logic [NUMBER_CHANNELS-1:0]                   CC_CMP_ARBITER_lessthan_OutBUS,
`endif
   output logic                                         CC_CMP_ARBITER_busy_Out
);
   localparam int unsigned CW = idx_w(NUMBER_CHANNELS);
   localparam int W = NUMBER_DATAWIDTH;

   state_e                     state_q;
   logic [CW-1:0]              ptr_q, win_q, win_d, chan_q;
   logic [W-1:0]               a_q, b_q;
   logic [NUMBER_CHANNELS-1:0] grant_q;
   logic                       valid_q, busy_q, lt_q, lt_n;
`ifdef CC_CMP_ARBITER_RESULTS_EN
   logic [NUMBER_CHANNELS-1:0] res_q;
   assign CC_CMP_ARBITER_lessthan_OutBUS = res_q;
`endif

   // Descending scan so the requester closest to the pointer is written last and wins.
   always_comb begin
      win_d = ptr_q;
      for (int i = NUMBER_CHANNELS - 1; i >= 0; i--)
         if (CC_CMP_ARBITER_req_InBUS[ptr_q + CW'(i)]) win_d = ptr_q + CW'(i);
   end

   cc_cmp_core #(.W(W)) u_core (.a_i(a_q), .b_i(b_q), .lt_n_o(lt_n));

   always_ff @(posedge CC_CMP_ARBITER_CLOCK_50 or negedge CC_CMP_ARBITER_RESET_InLow)
      if (!CC_CMP_ARBITER_RESET_InLow) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         win_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         grant_q <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         chan_q  <= '0;
         lt_q    <= 1'b1;
`ifdef CC_CMP_ARBITER_RESULTS_EN
         res_q   <= '1;
`endif
      end else
         case (state_q)
            IDLE:
               if (|CC_CMP_ARBITER_req_InBUS) begin
                  state_q <= LOAD;
                  win_q   <= win_d;
                  busy_q  <= 1'b1;
               end
            LOAD: begin
               a_q     <= CC_CMP_ARBITER_dataA_InBUS[win_q*W +: W];
               b_q     <= CC_CMP_ARBITER_dataB_InBUS[win_q*W +: W];
               state_q <= COMPARE;
            end
            // Results land on entry to DONE so they are visible during the DONE cycle.
            COMPARE: begin
               lt_q    <= lt_n;
               chan_q  <= win_q;
               grant_q <= NUMBER_CHANNELS'(1) << win_q;
               valid_q <= 1'b1;
`ifdef CC_CMP_ARBITER_RESULTS_EN
               res_q[win_q] <= lt_n;
`endif
               state_q <= DONE;
            end
            DONE: begin
               grant_q <= '0;
               valid_q <= 1'b0;
               busy_q  <= 1'b0;
               ptr_q   <= win_q + CW'(1);
               state_q <= IDLE;
            end
         endcase

   assign CC_CMP_ARBITER_grant_OutBUS    = grant_q;
   assign CC_CMP_ARBITER_valid_Out       = valid_q;
   assign CC_CMP_ARBITER_channel_OutBUS  = chan_q;
   assign CC_CMP_ARBITER_lessthan_OutLow = lt_q;
   assign CC_CMP_ARBITER_busy_Out        = busy_q;
endmodule

// File: tb/tb_cc_cmp_arbiter.sv
// tb_cc_cmp_arbiter: directed scoreboard bench for cc_cmp_arbiter (4 channels, 8-bit operands).
module tb_cc_cmp_arbiter;
   localparam int N = 4;
   localparam int W = 8;

   typedef struct {
      logic [N-1:0] g;
      logic [1:0]   c;
      logic         lt;
   } exp_t;

   logic           clk, rst_n, valid, lt_n, busy;
   logic [N-1:0]   req, grant;
   logic [N*W-1:0] da, db;
   logic [1:0]     chan;
`ifdef CC_CMP_ARBITER_RESULTS_EN
   logic [N-1:0]   res;
`endif
   exp_t           q[$];
   int             n_chk = 0;
   int             n_pass = 0;

   cc_cmp_arbiter #(.NUMBER_DATAWIDTH(W), .NUMBER_CHANNELS(N)) dut (
      .CC_CMP_ARBITER_CLOCK_50       (clk),
      .CC_CMP_ARBITER_RESET_InLow    (rst_n),
      .CC_CMP_ARBITER_req_InBUS      (req),
      .CC_CMP_ARBITER_dataA_InBUS    (da),
      .CC_CMP_ARBITER_dataB_InBUS    (db),
      .CC_CMP_ARBITER_grant_OutBUS   (grant),
      .CC_CMP_ARBITER_valid_Out      (valid),
      .CC_CMP_ARBITER_channel_OutBUS (chan),
      .CC_CMP_ARBITER_lessthan_OutLow(lt_n),
`ifdef CC_CMP_ARBITER_RESULTS_EN
      .CC_CMP_ARBITER_lessthan_OutBUS(res),
`endif
      .CC_CMP_ARBITER_busy_Out       (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_grant"}, 32'(grant), 0);
      chk({tag, "_valid"}, 32'(valid), 0);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_chan"}, 32'(chan), 0);
      chk({tag, "_lt"}, 32'(lt_n), 1);
   endtask

   task automatic set_ch(input int ch, input logic [7:0] a, input logic [7:0] b);
      da[ch*W +: W] = a;
      db[ch*W +: W] = b;
   endtask

   task automatic push(input int ch, input logic [7:0] a, input logic [7:0] b);
      q.push_back('{g: 4'(1) << ch, c: 2'(ch), lt: (a < b) ? 1'b0 : 1'b1});
   endtask

   task automatic go(input int ch, input logic [7:0] a, input logic [7:0] b);
      @(negedge clk);
      set_ch(ch, a, b);
      req[ch] = 1'b1;
      push(ch, a, b);
   endtask

   // Waits (bounded) for the valid pulse, checking latency, busy cycles and the scoreboard head.
   task automatic wait_done(input string tag, input int exp_lat, input int exp_busy);
      int   n = 0;
      int   nb = 0;
      exp_t e;
      do begin
         @(negedge clk);
         n++;
         if (busy) nb++;
      end while (!valid && n < 16);
      chk({tag, "_lat"}, n, exp_lat);
      chk({tag, "_busycyc"}, nb, exp_busy);
      if (valid) begin
         chk({tag, "_qnonempty"}, 32'(q.size() > 0), 1);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk({tag, "_grant"}, 32'(grant), 32'(e.g));
            chk({tag, "_chan"}, 32'(chan), 32'(e.c));
            chk({tag, "_lt"}, 32'(lt_n), 32'(e.lt));
         end
      end
   endtask

   // Next cycle: requester drops req; results must hold while the pulse ends.
   task automatic drop(input string tag, input logic [N-1:0] mask, input logic exp_lt, input int exp_ch);
      @(negedge clk);
      req = req & ~mask;
      chk({tag, "_pulse_valid"}, 32'(valid), 0);
      chk({tag, "_pulse_grant"}, 32'(grant), 0);
      chk({tag, "_hold_lt"}, 32'(lt_n), 32'(exp_lt));
      chk({tag, "_hold_chan"}, 32'(chan), exp_ch);
   endtask

   initial begin
      clk = 1'b0;
      rst_n = 1'b0;
      req = '0;
      da = '0;
      db = '0;
      @(negedge clk);
      chk_reset("rst");
`ifdef CC_CMP_ARBITER_RESULTS_EN
      chk("rst_res", 32'(res), 32'hF);
`endif
      @(negedge clk);
      rst_n = 1'b1;

      // All four requesting: round robin 0,1,2,3,0
      @(negedge clk);
      for (int i = 0; i < N; i++) set_ch(i, 8'(i * 8'h11), 8'h22);
      req = 4'hF;
      for (int i = 0; i < 5; i++) push(i % N, 8'((i % N) * 8'h11), 8'h22);
      wait_done("rr0", 3, 3);
      wait_done("rr1", 4, 3);
      wait_done("rr2", 4, 3);
      wait_done("rr3", 4, 3);
      wait_done("rr4", 4, 3);
      drop("rr", 4'hF, 1'b0, 0);

      go(2, 8'h10, 8'h20);
      wait_done("ch2", 3, 3);
      drop("ch2", 4'b0100, 1'b0, 2);

      go(0, 8'h55, 8'h55);
      wait_done("eq", 3, 3);
      drop("eq", 4'b0001, 1'b1, 0);
      go(0, 8'hFF, 8'h00);
      wait_done("ff_00", 3, 3);
      drop("ff_00", 4'b0001, 1'b1, 0);
      go(0, 8'h00, 8'hFF);
      wait_done("00_ff", 3, 3);
      drop("00_ff", 4'b0001, 1'b0, 0);

      // Operands frozen at LOAD: change A and drop req during COMPARE
      go(1, 8'h80, 8'h40);
      @(negedge clk);
      @(negedge clk);
      set_ch(1, 8'h00, 8'h40);
      req[1] = 1'b0;
      wait_done("frozen", 1, 1);
      drop("frozen", 4'b0000, 1'b1, 1);

      // Reset during COMPARE of ch3 aborts; pointer returns to 0
      @(negedge clk);
      set_ch(3, 8'h01, 8'h02);
      req = 4'b1000;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk_reset("abort");
      set_ch(1, 8'h03, 8'h04);
      set_ch(3, 8'h06, 8'h05);
      req = 4'b1010;
      @(negedge clk);
      chk_reset("abort_hold");
      rst_n = 1'b1;
      push(1, 8'h03, 8'h04);
      wait_done("post_rst1", 3, 3);
      drop("post_rst1", 4'b0010, 1'b0, 1);
      push(3, 8'h06, 8'h05);
      wait_done("post_rst3", 3, 3);
      drop("post_rst3", 4'b1000, 1'b1, 3);

      // Per-channel result register
      @(negedge clk);
      rst_n = 1'b0;
      #1;
`ifdef CC_CMP_ARBITER_RESULTS_EN
      chk("res_rst", 32'(res), 32'hF);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      go(0, 8'h01, 8'h02);
      wait_done("res0", 3, 3);
`ifdef CC_CMP_ARBITER_RESULTS_EN
      chk("res_after0", 32'(res), 32'hE);
`endif
      drop("res0", 4'b0001, 1'b0, 0);
      go(3, 8'h09, 8'h03);
      wait_done("res3", 3, 3);
`ifdef CC_CMP_ARBITER_RESULTS_EN
      chk("res_after3", 32'(res), 32'hE);
`endif
      drop("res3", 4'b1000, 1'b1, 3);

      chk("scoreboard_empty", 32'(q.size()), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
